reg_mux_scanner: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer; next generation of the 4:1 clocked selector.
- Manual mode: select comes from the `sel` port.
- Auto-scan mode: an internal channel counter cycles through the channels, dwelling a programmable number of cycles on each.
- Sits between sampled input sources and downstream display/capture logic. Reports which channel is on the output and when a scan pass wraps.

---
 rtl/mux_pkg.sv | 17 +
 rtl/reg_mux_scanner_next_ch_finder.sv | 38 +++
 rtl/reg_mux_scanner.sv | 144 ++++++++++++++
 tb/tb_reg_mux_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared encodings for the registered mux/scanner: FSM state values and mode input levels.
package mux_pkg;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] MANUAL_ENC = 2'd1;
  localparam logic [1:0] SCAN_ENC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = IDLE_ENC,
    MANUAL = MANUAL_ENC,
    SCAN   = SCAN_ENC
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/reg_mux_scanner_next_ch_finder.sv
// Cyclic search for the next enabled channel strictly after cur_i; if the search passes the
// last channel it restarts at 0 and reports wrapped_o (this includes landing back on cur_i).
module next_ch_finder #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    cur_i,
  input  logic [CHANNELS-1:0] mask_i,
  output logic [SEL_W-1:0]    next_o,
  output logic                found_o,
  output logic                wrapped_o
);

  logic [SEL_W-1:0] up_idx, low_idx;
  logic             up_ok, low_ok;

  always_comb begin
    up_idx  = '0;
    low_idx = '0;
    up_ok   = 1'b0;
    low_ok  = 1'b0;
    // Descending scans leave the lowest qualifying index in each candidate.
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (mask_i[j] && (j > int'(cur_i))) begin
        up_idx = SEL_W'(j);
        up_ok  = 1'b1;
      end
      if (mask_i[j] && (j <= int'(cur_i))) begin
        low_idx = SEL_W'(j);
        low_ok  = 1'b1;
      end
    end
    next_o    = up_ok ? up_idx : low_idx;
    found_o   = up_ok | low_ok;
    wrapped_o = !up_ok && low_ok;
  end

endmodule

// File: rtl/reg_mux_scanner.sv
// Registered N:1 mux with manual select or timed auto-scan over the channels.
// Build option MUX_CHANNEL_MASK_EN adds ch_mask (1 = channel enabled); otherwise all enabled.
module reg_mux_scanner
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
`ifdef MUX_CHANNEL_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_ch,
  output logic                      dout_valid,
  output logic                      wrap
);

  localparam int               NSLOT      = 1 << SEL_W;
  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] dout_ch_q, dout_ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  // Select slots beyond CHANNELS read as disabled zero data, so invalid selects need no special case.
  logic [WIDTH-1:0] chan [NSLOT];
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < CHANNELS) begin : g_real
      assign chan[i] = din[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[i] = '0;
    end
  end

  logic [CHANNELS-1:0] mask;
`ifdef MUX_CHANNEL_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif
  logic [NSLOT-1:0] mask_slot;
  assign mask_slot = NSLOT'(mask);

  // Outside scan the finder searches from the last channel, giving the first enabled one to park on.
  logic [SEL_W-1:0] find_cur, find_next, park_ch, pick;
  logic             find_ok, find_wrap;
  assign find_cur = (state_q != IDLE && mode == MODE_SCAN) ? ch_q : CH_LAST;
  assign park_ch  = find_ok ? find_next : '0;
  assign pick     = (mode == MODE_SCAN) ? ch_q : sel;

  next_ch_finder #(.CHANNELS(CHANNELS)) u_find (
    .cur_i    (find_cur),
    .mask_i   (mask),
    .next_o   (find_next),
    .found_o  (find_ok),
    .wrapped_o(find_wrap)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dwell_d   = dwell_q;
    pend_d    = pend_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    if (!hold) begin
      if (state_q == IDLE) begin
        state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
        ch_d    = park_ch;
        dwell_d = '0;
        pend_d  = 1'b0;
      end else begin
        dout_ch_d = pick;
        valid_d   = mask_slot[pick];
        dout_d    = mask_slot[pick] ? chan[pick] : '0;
        if (mode == MODE_MANUAL) begin
          state_d = MANUAL;
          ch_d    = park_ch;
          dwell_d = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = SCAN;
          // A wrap is flagged at the advance and shown on the edge that first outputs the new channel.
          wrap_d  = pend_q;
          pend_d  = 1'b0;
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (find_ok) begin
              ch_d   = find_next;
              pend_d = find_wrap;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      dwell_q   <= '0;
      pend_q    <= 1'b0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dwell_q   <= dwell_d;
      pend_q    <= pend_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_reg_mux_scanner.sv
// Scoreboard bench for reg_mux_scanner (3 channels so an out-of-range select is reachable).
module tb_reg_mux_scanner;

  localparam int W    = 4;
  localparam int CH   = 3;
  localparam int DW   = 3;
  localparam int SW   = 2;
  localparam int DINW = CH * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DINW-1:0] din = '0;
  logic [SW-1:0]   sel = '0;
  logic            mode = 1'b0;
  logic            hold = 1'b0;
  logic [W-1:0]    dout;
  logic [SW-1:0]   dout_ch;
  logic            dout_valid;
  logic            wrap;
  logic [CH-1:0]   m_mask = '1;
`ifdef MUX_CHANNEL_MASK_EN
  logic [CH-1:0]   ch_mask = '1;
`endif

  reg_mux_scanner #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .hold      (hold),
`ifdef MUX_CHANNEL_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .dout      (dout),
    .dout_ch   (dout_ch),
    .dout_valid(dout_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] c;
    logic          v;
    logic          w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Reference model: behaviour described as channel/time-slot bookkeeping.
  bit   m_run = 1'b0;
  int   m_ch = 0;
  int   m_cnt = 0;
  bit   m_pend = 1'b0;
  exp_t m_out = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan_of(input int i);
    logic [DINW-1:0] v = din;
    return v[i*W +: W];
  endfunction

  function automatic int first_en();
    for (int i = 0; i < CH; i++) if (m_mask[i]) return i;
    return 0;
  endfunction

  function automatic int next_en(input int cur);
    for (int k = 1; k <= CH; k++) if (m_mask[(cur + k) % CH]) return (cur + k) % CH;
    return cur;
  endfunction

  task automatic model_edge();
    exp_t o = m_out;
    int   s = int'(sel);
    int   nx;
    o.w = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_ch = 0; m_cnt = 0; m_pend = 0;
      o = '0;
    end else if (hold) begin
      // everything frozen, wrap suppressed
    end else if (!m_run) begin
      m_run = 1; m_ch = first_en(); m_cnt = 0; m_pend = 0;
    end else if (!mode) begin
      o.c = SW'(s);
      o.v = (s < CH) ? m_mask[s] : 1'b0;
      o.d = o.v ? chan_of(s) : '0;
      m_ch = first_en(); m_cnt = 0; m_pend = 0;
    end else begin
      o.c = SW'(m_ch);
      o.v = m_mask[m_ch];
      o.d = o.v ? chan_of(m_ch) : '0;
      o.w = m_pend;
      m_pend = 0;
      m_cnt++;
      if (m_cnt == DW) begin
        m_cnt = 0;
        if (m_mask != 0) begin
          nx = next_en(m_ch);
          m_pend = (nx <= m_ch);
          m_ch = nx;
        end
      end
    end
    m_out = o;
    q.push_back(o);
  endtask

  task automatic drive(input logic r, input int s, input logic m, input logic h);
    @(negedge clk);
    mon_en = 1'b1;
    sel  = SW'(s);
    mode = m;
    hold = h;
    din  = DINW'($urandom);
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      chk("async_rst_dout", int'(dout), 0);
      chk("async_rst_ch", int'(dout_ch), 0);
      chk("async_rst_valid", int'(dout_valid), 0);
      chk("async_rst_wrap", int'(wrap), 0);
    end else begin
      rst_n = r;
    end
    model_edge();
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      #1;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 entries expected>=1 at t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("dout", int'(dout), int'(e.d));
        chk("dout_ch", int'(dout_ch), int'(e.c));
        chk("dout_valid", int'(dout_valid), int'(e.v));
        chk("wrap", int'(wrap), int'(e.w));
      end
    end
  end

  initial begin
    int  s;
    bit  m;
    // Reset, then manual select with the first edge spent in IDLE.
    repeat (2) drive(0, 2, 0, 0);
    repeat (3) drive(1, 2, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 3, 0, 0);
    drive(1, 3, 0, 0);
    drive(1, 2, 0, 0);
    // Two full scan passes, then back to manual.
    repeat (2 * CH * DW + 2) drive(1, 1, 1, 0);
    repeat (2) drive(1, 0, 0, 0);
    // Scan to the second cycle on ch1, hold 5 cycles with a mode toggle inside.
    repeat (DW + 2) drive(1, 0, 1, 0);
    drive(1, 0, 1, 1);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(1, 0, 1, 1);
    drive(1, 0, 1, 1);
    repeat (2 * DW) drive(1, 0, 1, 0);
    // Reset in the middle of a scan; scan restarts from ch0.
    repeat (4) drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    repeat (CH * DW + 3) drive(1, 0, 1, 0);
    // Randomized traffic.
    m = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) m = ~m;
      s = int'($urandom_range(0, 3));
`ifdef MUX_CHANNEL_MASK_EN
      if ($urandom_range(0, 29) == 0) begin
        ch_mask = CH'($urandom);
        m_mask  = ch_mask;
      end
`endif
      drive(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, s, m,
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
